sink_table_builder: RTL and testbench

Writer side of the known-sink table consumed by the sink-lookup logic in the cost-evaluation path. Accepts sink-ID announcements one at a time and scans the existing table sequentially for a duplicate, one entry per clock. A new ID is appended to the flattened table only if it is absent and a slot is free. Publishes the packed table, a per-slot valid mask and an entry count; every request reports a completion status.

---
 rtl/sink_table_builder_if.sv | 39 +++
 rtl/sink_table_builder.sv | 182 ++++++++++++++++++
 tb/tb_sink_table_builder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sink_table_builder_if.sv
// ---------------------------------------------------------------------------
// sink_table_builder_if
// Bundles the request handshake and the published table of the known-sink
// table writer.
//   clear       master->slave  synchronous table flush (honored while idle)
//   add_valid   master->slave  request to add add_id
//   add_id      master->slave  sink ID to add (any value, including 0)
//   add_ready   slave->master  request accepted when add_valid && add_ready
//   done        slave->master  one-cycle pulse when a request finishes
//   status      slave->master  00 inserted, 01 duplicate, 10 full
//   knownSinks  slave->master  packed table, slot i at [ID_W*i +: ID_W]
//   sink_valid  slave->master  bit i set = slot i occupied
//   sink_count  slave->master  number of occupied slots
// ---------------------------------------------------------------------------
interface sink_table_builder_if #(
    parameter int NUM_SINKS = 10,
    parameter int ID_W      = 5,
    parameter int CNT_W     = 4
);
    logic                      clear;
    logic                      add_valid;
    logic [ID_W-1:0]           add_id;
    logic                      add_ready;
    logic                      done;
    logic [1:0]                status;
    logic [NUM_SINKS*ID_W-1:0] knownSinks;
    logic [NUM_SINKS-1:0]      sink_valid;
    logic [CNT_W-1:0]          sink_count;

    modport master (
        output clear, add_valid, add_id,
        input  add_ready, done, status, knownSinks, sink_valid, sink_count
    );

    modport slave (
        input  clear, add_valid, add_id,
        output add_ready, done, status, knownSinks, sink_valid, sink_count
    );
endinterface

// File: rtl/sink_table_builder.sv
// ---------------------------------------------------------------------------
// sink_table_builder
// Writer side of the known-sink table. Each accepted sink ID is compared
// against the occupied slots one per clock; an absent ID is appended at the
// first free slot if one exists. Every request ends with a one-cycle done
// pulse and a held completion status.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    sink_table_builder_if.slave (request handshake + published table)
// ---------------------------------------------------------------------------
module sink_table_builder #(
    parameter int NUM_SINKS = 10,
    parameter int ID_W      = 5,
    parameter int CNT_W     = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    sink_table_builder_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_INSERT,
        S_DONE
    } state_t;

    localparam logic [1:0] ST_INSERTED  = 2'b00;
    localparam logic [1:0] ST_DUPLICATE = 2'b01;
    localparam logic [1:0] ST_FULL      = 2'b10;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         reqId_q, reqId_d;
    logic [CNT_W-1:0]        idx_q, idx_d;
    logic [1:0]              status_q, status_d;
    logic [ID_W-1:0]         slots_q [NUM_SINKS];
    logic [ID_W-1:0]         slots_d [NUM_SINKS];
    logic [NUM_SINKS-1:0]    valid_q, valid_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic                    addReady;
    logic                    accept;
    logic [ID_W-1:0]         curSlot;
    logic                    hit;
    logic                    lastIdx;
    logic                    tableFull;
    logic [NUM_SINKS*ID_W-1:0] knownFlat;

    // Slot under inspection during the scan; an explicit mux keeps the
    // narrow index from ever addressing past the table.
    always_comb begin
        curSlot = '0;
        for (int i = 0; i < NUM_SINKS; i++) begin
            if (CNT_W'(i) == idx_q) begin
                curSlot = slots_q[i];
            end
        end
    end

    assign accept    = addReady && bus.add_valid;
    assign hit       = (curSlot == reqId_q);
    assign lastIdx   = (idx_q == count_q - CNT_W'(1));
    assign tableFull = (count_q == CNT_W'(NUM_SINKS));

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. An empty table skips the scan and inserts directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (count_q != '0) ? S_SCAN : S_INSERT;
                end
            end
            S_SCAN: begin
                if (hit) begin
                    state_d = S_DONE;
                end else if (lastIdx) begin
                    state_d = tableFull ? S_DONE : S_INSERT;
                end
            end
            S_INSERT: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state. add_ready is also held low during reset
    // so nothing is offered to the requester until reset is released.
    always_comb begin
        addReady = (state_q == S_IDLE) && !bus.clear && !rst_i;
        bus.done = (state_q == S_DONE);
    end

    // Datapath next-state: request latch, scan index, status and the table.
    // The table only changes on a flush in IDLE or on the INSERT cycle.
    always_comb begin
        reqId_d  = reqId_q;
        idx_d    = idx_q;
        status_d = status_q;
        slots_d  = slots_q;
        valid_d  = valid_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.clear) begin
                    slots_d = '{default: '0};
                    valid_d = '0;
                    count_d = '0;
                end else if (accept) begin
                    reqId_d = bus.add_id;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (hit) begin
                    status_d = ST_DUPLICATE;
                end else if (lastIdx) begin
                    if (tableFull) begin
                        status_d = ST_FULL;
                    end
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            S_INSERT: begin
                for (int i = 0; i < NUM_SINKS; i++) begin
                    if (CNT_W'(i) == count_q) begin
                        slots_d[i] = reqId_q;
                        valid_d[i] = 1'b1;
                    end
                end
                count_d  = count_q + CNT_W'(1);
                status_d = ST_INSERTED;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reqId_q  <= '0;
            idx_q    <= '0;
            status_q <= ST_INSERTED;
            slots_q  <= '{default: '0};
            valid_q  <= '0;
            count_q  <= '0;
        end else begin
            reqId_q  <= reqId_d;
            idx_q    <= idx_d;
            status_q <= status_d;
            slots_q  <= slots_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    // Flatten the slot array into the published packed table.
    always_comb begin
        knownFlat = '0;
        for (int i = 0; i < NUM_SINKS; i++) begin
            knownFlat[ID_W*i +: ID_W] = slots_q[i];
        end
    end

    assign bus.add_ready  = addReady;
    assign bus.status     = status_q;
    assign bus.knownSinks = knownFlat;
    assign bus.sink_valid = valid_q;
    assign bus.sink_count = count_q;

endmodule

// File: tb/tb_sink_table_builder.sv
// ---------------------------------------------------------------------------
// tb_sink_table_builder
// Directed bench for sink_table_builder. The driver pushes the expected
// status and latency of each request into a queue; a monitor pops and
// compares on every done pulse. Table contents are compared directly.
// ---------------------------------------------------------------------------
module tb_sink_table_builder;

    localparam int NUM_SINKS = 10;
    localparam int ID_W      = 5;
    localparam int CNT_W     = 4;

    typedef struct {
        logic [1:0] st;
        int         lat;
        int         acc;
    } exp_t;

    logic clk;
    logic rst;
    int   cycleCount;
    int   compared;
    int   mismatched;
    exp_t expQ[$];
    exp_t monExp;

    sink_table_builder_if #(
        .NUM_SINKS(NUM_SINKS),
        .ID_W     (ID_W),
        .CNT_W    (CNT_W)
    ) bus ();

    sink_table_builder #(
        .NUM_SINKS(NUM_SINKS),
        .ID_W     (ID_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    // Clock and edge counter used to measure request latency.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
    end

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (expQ.size() == 0) begin
                compared   = compared + 1;
                mismatched = mismatched + 1;
                $display("[TB] FAIL unexpected_done: done=1 required no done at cycle %0d", cycleCount);
            end else begin
                monExp = expQ.pop_front();
                compared = compared + 2;
                if (bus.status !== monExp.st) begin
                    mismatched = mismatched + 1;
                    $display("[TB] FAIL status: actual %b required %b", bus.status, monExp.st);
                end
                if (cycleCount - monExp.acc + 1 != monExp.lat) begin
                    mismatched = mismatched + 1;
                    $display("[TB] FAIL latency: actual %0d required %0d", cycleCount - monExp.acc + 1, monExp.lat);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        compared = compared + 1;
        if (act !== req) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Waits (bounded) for add_ready at a falling edge.
    task automatic waitReady();
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.add_ready === 1'b1) break;
        end
        if (k == 60) begin
            checkOutput("ready_timeout", 64'd0, 64'd1);
        end
    endtask

    // Issues one request; returns at the falling edge after the accept edge.
    task automatic applyStimulus(input logic [ID_W-1:0] id, input logic [1:0] st,
                                 input int lat, input bit push);
        exp_t e;
        waitReady();
        bus.add_valid = 1'b1;
        bus.add_id    = id;
        e.st  = st;
        e.lat = lat;
        e.acc = cycleCount + 1;
        if (push) expQ.push_back(e);
        @(negedge clk);
        bus.add_valid = 1'b0;
    endtask

    // Bounded wait until the monitor has consumed every expectation.
    task automatic waitDone();
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (expQ.size() == 0) break;
        end
        if (expQ.size() != 0) begin
            checkOutput("done_timeout", 64'(expQ.size()), 64'd0);
            expQ.delete();
        end
    endtask

    task automatic doClear();
        waitReady();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic addOne(input logic [ID_W-1:0] id, input logic [1:0] st, input int lat);
        applyStimulus(id, st, lat, 1'b1);
        waitDone();
    endtask

    initial begin
        exp_t e;
        cycleCount    = 0;
        compared      = 0;
        mismatched    = 0;
        rst           = 1'b1;
        bus.clear     = 1'b0;
        bus.add_valid = 1'b0;
        bus.add_id    = '0;

        // Reset state.
        #1;
        checkOutput("rst_ready", 64'(bus.add_ready), 64'd0);
        checkOutput("rst_count", 64'(bus.sink_count), 64'd0);
        checkOutput("rst_valid", 64'(bus.sink_valid), 64'd0);
        checkOutput("rst_table", 64'(bus.knownSinks), 64'd0);
        checkOutput("rst_status", 64'(bus.status), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rel_ready", 64'(bus.add_ready), 64'd1);

        // Inserts into an empty table: 3, 7, 0.
        addOne(5'd3, 2'b00, 2);
        addOne(5'd7, 2'b00, 3);
        addOne(5'd0, 2'b00, 4);
        checkOutput("ins_count", 64'(bus.sink_count), 64'd3);
        checkOutput("ins_valid", 64'(bus.sink_valid), 64'h007);
        checkOutput("ins_low15", 64'(bus.knownSinks[14:0]), 64'(15'b00000_00111_00011));
        checkOutput("ins_high", 64'(bus.knownSinks[49:15]), 64'd0);

        // Duplicates.
        addOne(5'd7, 2'b01, 3);
        addOne(5'd0, 2'b01, 4);
        checkOutput("dup_count", 64'(bus.sink_count), 64'd3);
        checkOutput("dup_low15", 64'(bus.knownSinks[14:0]), 64'(15'b00000_00111_00011));

        // Fill 0..9, then full and duplicate-at-last-slot.
        doClear();
        for (int k = 0; k < NUM_SINKS; k++) begin
            addOne(ID_W'(k), 2'b00, k + 2);
        end
        checkOutput("fill_count", 64'(bus.sink_count), 64'd10);
        checkOutput("fill_valid", 64'(bus.sink_valid), 64'h3FF);
        checkOutput("fill_slot9", 64'(bus.knownSinks[49:45]), 64'd9);
        addOne(5'd12, 2'b10, 11);
        checkOutput("full_count", 64'(bus.sink_count), 64'd10);
        addOne(5'd9, 2'b01, 11);

        // Clear together with add in IDLE on a 4-entry table.
        doClear();
        for (int k = 1; k <= 4; k++) begin
            addOne(ID_W'(k), 2'b00, k + 1);
        end
        checkOutput("pre_clr_count", 64'(bus.sink_count), 64'd4);
        waitReady();
        bus.clear     = 1'b1;
        bus.add_valid = 1'b1;
        bus.add_id    = 5'd20;
        #1;
        checkOutput("clr_ready", 64'(bus.add_ready), 64'd0);
        @(negedge clk);
        checkOutput("clr_count", 64'(bus.sink_count), 64'd0);
        checkOutput("clr_valid", 64'(bus.sink_valid), 64'd0);
        checkOutput("clr_table", 64'(bus.knownSinks), 64'd0);
        checkOutput("clr_done", 64'(bus.done), 64'd0);
        bus.clear = 1'b0;
        e.st  = 2'b00;
        e.lat = 2;
        e.acc = cycleCount + 1;
        expQ.push_back(e);
        @(negedge clk);
        bus.add_valid = 1'b0;
        waitDone();
        checkOutput("after_clr_count", 64'(bus.sink_count), 64'd1);
        checkOutput("after_clr_slot0", 64'(bus.knownSinks[4:0]), 64'd20);

        // Reset in the middle of a scan on a 5-entry table.
        for (int k = 21; k <= 24; k++) begin
            addOne(ID_W'(k), 2'b00, k - 18);
        end
        checkOutput("pre_rst_count", 64'(bus.sink_count), 64'd5);
        applyStimulus(5'd25, 2'b00, 7, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_count", 64'(bus.sink_count), 64'd0);
        checkOutput("mid_rst_valid", 64'(bus.sink_valid), 64'd0);
        checkOutput("mid_rst_table", 64'(bus.knownSinks), 64'd0);
        checkOutput("mid_rst_status", 64'(bus.status), 64'd0);
        checkOutput("mid_rst_ready", 64'(bus.add_ready), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("mid_rel_ready", 64'(bus.add_ready), 64'd1);
        repeat (15) @(negedge clk);
        checkOutput("post_rst_count", 64'(bus.sink_count), 64'd0);

        // Latched ID and clear ignored during scan.
        addOne(5'd5, 2'b00, 2);
        addOne(5'd6, 2'b00, 3);
        applyStimulus(5'd9, 2'b00, 4, 1'b1);
        bus.add_id = 5'd30;
        bus.clear  = 1'b1;
        @(negedge clk);
        bus.clear  = 1'b0;
        waitDone();
        checkOutput("latch_count", 64'(bus.sink_count), 64'd3);
        checkOutput("latch_valid", 64'(bus.sink_valid), 64'h007);
        checkOutput("latch_slot2", 64'(bus.knownSinks[14:10]), 64'd9);
        checkOutput("latch_slot0", 64'(bus.knownSinks[4:0]), 64'd5);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
